// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared FSM encoding and bus bit constants for the I2C slave.
// Revision    : 1.0
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } i2c_state_e;

    localparam logic       c_ACK        = 1'b0;
    localparam logic       c_NACK       = 1'b1;
    localparam logic [3:0] c_LAST_BIT   = 4'd7;
    localparam logic [3:0] c_BYTE_BITS  = 4'd8;

    function automatic logic is_busy_state(input i2c_state_e s);
        return !((s == IDLE) || (s == IGNORE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_in_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_in_filter
// Description : 2-flop synchroniser followed by a FILT_LEN-sample glitch filter.
// Revision    : 1.0
// ============================================================================
module i2c_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o
);

    logic [1:0]          sync_q;
    logic [FILT_LEN-1:0] hist_q;
    logic [FILT_LEN-1:0] hist_d;
    logic                level_q;
    logic                level_d;

    generate
        if (FILT_LEN == 1) begin : g_len1
            assign hist_d = sync_q[1];
        end else begin : g_lenn
            assign hist_d = {hist_q[FILT_LEN-2:0], sync_q[1]};
        end
    endgenerate

    // The level only moves once the whole history window agrees.
    always_comb begin
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            hist_q  <= '1;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], in_i};
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

    assign out_o = level_q;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_burst.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_burst
// Description : I2C register slave with auto-incrementing burst read/write.
// Revision    : 1.0
// ============================================================================
module i2c_slave_burst
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         REG_AW   = 5,
    parameter int         FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_o,
    output logic              scl_t,
    output logic              sda_o,
    output logic              sda_t,
    output logic [REG_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              nack_err
);

    logic w_scl_f;
    logic w_sda_f;
    logic scl_prev_q;
    logic sda_prev_q;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .rst   (rst),
        .in_i  (scl_i),
        .out_o (w_scl_f)
    );

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .rst   (rst),
        .in_i  (sda_i),
        .out_o (w_sda_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= w_scl_f;
            sda_prev_q <= w_sda_f;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl_f & ~scl_prev_q;
    assign w_scl_fall = ~w_scl_f & scl_prev_q;
    assign w_start    = w_scl_f & scl_prev_q & sda_prev_q & ~w_sda_f;
    assign w_stop     = w_scl_f & scl_prev_q & ~sda_prev_q & w_sda_f;

    i2c_state_e        state_q;
    logic [REG_AW-1:0] ptr_q;
    logic [REG_AW-1:0] ptr_d;
    logic [3:0]        bitcnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic [7:0]        rdata_q;
    logic              ack_phase_q;
    logic              rw_q;
    logic              acked_q;
    logic              sda_t_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [7:0]        mem_wdata_q;
    logic              re_dly_q;
    logic              nack_err_q;
    logic              w_byte_done;

    assign shift_d     = {shift_q[6:0], w_sda_f};
    assign ptr_d       = ptr_q + REG_AW'(1);
    assign w_byte_done = w_scl_rise && (bitcnt_q == c_LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            acked_q     <= 1'b0;
            sda_t_q     <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            re_dly_q    <= 1'b0;
            nack_err_q  <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            re_dly_q <= mem_re_q;

            // Read data arrives one clk after the strobe; drive MSB at once
            // only when SCL is already in the low phase of the first bit.
            if (re_dly_q) begin
                rdata_q <= mem_rdata;
                if (state_q == RDATA) begin
                    sda_t_q <= mem_rdata[7];
                end
            end

            if (w_start) begin
                state_q     <= ADDR;
                bitcnt_q    <= '0;
                ack_phase_q <= 1'b0;
                acked_q     <= 1'b0;
                sda_t_q     <= 1'b1;
            end else if (w_stop) begin
                state_q     <= IDLE;
                bitcnt_q    <= '0;
                ack_phase_q <= 1'b0;
                sda_t_q     <= 1'b1;
            end else begin
                unique case (state_q)
                    ADDR, PTR, WDATA: begin
                        if (w_scl_rise) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end
                        if (w_byte_done) begin
                            bitcnt_q <= '0;
                            if (state_q == ADDR) begin
                                rw_q    <= shift_d[0];
                                state_q <= (shift_d[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                            end else if (state_q == PTR) begin
                                ptr_q   <= shift_d[REG_AW-1:0];
                                state_q <= PTR_ACK;
                            end else begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= shift_d;
                                state_q     <= WDATA_ACK;
                            end
                        end
                    end

                    // First fall drives the ACK, second fall ends the 9th bit.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_t_q     <= c_ACK;
                                ack_phase_q <= 1'b1;
                            end else begin
                                ack_phase_q <= 1'b0;
                                sda_t_q     <= 1'b1;
                                if (state_q == ADDR_ACK) begin
                                    if (rw_q) begin
                                        state_q  <= RDATA;
                                        mem_re_q <= 1'b1;
                                    end else begin
                                        state_q <= PTR;
                                    end
                                end else if (state_q == PTR_ACK) begin
                                    state_q <= WDATA;
                                end else begin
                                    ptr_q   <= ptr_d;
                                    state_q <= WDATA;
                                end
                            end
                        end
                    end

                    RDATA: begin
                        if (w_scl_rise) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end
                        if (w_scl_fall) begin
                            if (bitcnt_q == c_BYTE_BITS) begin
                                bitcnt_q <= '0;
                                sda_t_q  <= 1'b1;
                                state_q  <= RDATA_ACK;
                            end else begin
                                sda_t_q <= rdata_q[6];
                                rdata_q <= {rdata_q[6:0], 1'b0};
                            end
                        end
                    end

                    RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda_f == c_ACK) begin
                                acked_q     <= 1'b1;
                                ptr_q       <= ptr_d;
                                mem_re_q    <= 1'b1;
                                ack_phase_q <= 1'b1;
                            end else begin
                                if (acked_q) begin
                                    nack_err_q <= 1'b1;
                                end
                                state_q <= IGNORE;
                            end
                        end
                        if (w_scl_fall && ack_phase_q) begin
                            ack_phase_q <= 1'b0;
                            bitcnt_q    <= '0;
                            sda_t_q     <= rdata_q[7];
                            state_q     <= RDATA;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

    assign scl_o     = 1'b0;
    assign scl_t     = 1'b1;
    assign sda_o     = 1'b0;
    assign sda_t     = sda_t_q;
    assign mem_addr  = ptr_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = is_busy_state(state_q);
    assign nack_err  = nack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_burst
// Description : Directed, table-driven bench for the I2C burst slave.
// Revision    : 1.0
// ============================================================================
module tb_i2c_slave_burst;

    localparam int         Q        = 10;
    localparam int         NV       = 24;
    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WR    = 2'd2;
    localparam logic [1:0] OP_RD    = 2'd3;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp;
        logic       exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic [4:0] mem_addr;
    logic       mem_we, mem_re;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, nack_err;

    logic [7:0]  mem [0:31];
    logic [12:0] we_log [$];
    logic [4:0]  re_log [$];
    int          sda_low_cnt = 0;
    int          both_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vecs [0:NV-1];

    assign sda_bus = m_sda & sda_t;

    i2c_slave_burst dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (m_scl),
        .sda_i     (sda_bus),
        .scl_o     (scl_o),
        .scl_t     (scl_t),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .nack_err  (nack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we) we_log.push_back({mem_addr, mem_wdata});
        if (mem_re) re_log.push_back(mem_addr);
        if (sda_t === 1'b0) sda_low_cnt++;
        if (mem_we && mem_re) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic s);
        m_sda = b;
        clks(Q);
        m_scl = 1'b1;
        clks(Q);
        s = sda_bus;
        clks(Q);
        m_scl = 1'b0;
        clks(Q);
    endtask

    task automatic do_start();
        m_sda = 1'b1;
        clks(Q);
        m_scl = 1'b1;
        clks(Q);
        m_sda = 1'b0;
        clks(Q);
        m_scl = 1'b0;
        clks(Q);
    endtask

    task automatic do_stop();
        m_sda = 1'b0;
        clks(Q);
        m_scl = 1'b1;
        clks(Q);
        m_sda = 1'b1;
        clks(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(mack, s);
    endtask

    task automatic set_vec(input int i, input logic [1:0] op, input logic [7:0] data,
                           input logic [7:0] exp, input logic exp_busy);
        vecs[i].op       = op;
        vecs[i].data     = data;
        vecs[i].exp      = exp;
        vecs[i].exp_busy = exp_busy;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        logic       b;
        logic [7:0] d;
        for (int i = lo; i <= hi; i++) begin
            case (vecs[i].op)
                OP_START: do_start();
                OP_STOP:  do_stop();
                OP_WR: begin
                    write_byte(vecs[i].data, b);
                    check($sformatf("vec%0d ack", i), b, vecs[i].exp[0]);
                end
                default: begin
                    read_byte(vecs[i].data[0], d);
                    check($sformatf("vec%0d rdata", i), d, vecs[i].exp);
                end
            endcase
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         snap_low;
        int         snap_we;
        int         snap_re;
        logic       b;
        logic [7:0] ack_b;

        for (int i = 0; i < 32; i++) mem[i] = 8'h80 + 8'(i);

        // write burst
        set_vec(0,  OP_START, 8'h00, 8'h00, 1'b1);
        set_vec(1,  OP_WR,    8'h84, 8'h00, 1'b1);
        set_vec(2,  OP_WR,    8'h03, 8'h00, 1'b1);
        set_vec(3,  OP_WR,    8'hAA, 8'h00, 1'b1);
        set_vec(4,  OP_WR,    8'hBB, 8'h00, 1'b1);
        set_vec(5,  OP_STOP,  8'h00, 8'h00, 1'b0);
        // pointer write, repeated start, wrapping read
        set_vec(6,  OP_START, 8'h00, 8'h00, 1'b1);
        set_vec(7,  OP_WR,    8'h84, 8'h00, 1'b1);
        set_vec(8,  OP_WR,    8'h1F, 8'h00, 1'b1);
        set_vec(9,  OP_START, 8'h00, 8'h00, 1'b1);
        set_vec(10, OP_WR,    8'h85, 8'h00, 1'b1);
        set_vec(11, OP_RD,    8'h00, 8'h9F, 1'b1);
        set_vec(12, OP_RD,    8'h00, 8'h80, 1'b1);
        set_vec(13, OP_RD,    8'h01, 8'h81, 1'b0);
        set_vec(14, OP_STOP,  8'h00, 8'h00, 1'b0);
        // foreign address
        set_vec(15, OP_START, 8'h00, 8'h00, 1'b1);
        set_vec(16, OP_WR,    8'h90, 8'h01, 1'b0);
        set_vec(17, OP_WR,    8'h12, 8'h01, 1'b0);
        set_vec(18, OP_STOP,  8'h00, 8'h00, 1'b0);
        // transfer after a reset
        set_vec(19, OP_START, 8'h00, 8'h00, 1'b1);
        set_vec(20, OP_WR,    8'h84, 8'h00, 1'b1);
        set_vec(21, OP_WR,    8'h07, 8'h00, 1'b1);
        set_vec(22, OP_WR,    8'h3C, 8'h00, 1'b1);
        set_vec(23, OP_STOP,  8'h00, 8'h00, 1'b0);

        clks(5);
        check("rst sda_t",     sda_t,     1);
        check("rst scl_t",     scl_t,     1);
        check("rst busy",      busy,      0);
        check("rst mem_we",    mem_we,    0);
        check("rst mem_re",    mem_re,    0);
        check("rst mem_addr",  mem_addr,  0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst nack_err",  nack_err,  0);
        rst = 1'b0;
        clks(20);

        run_vectors(0, 5);
        check("wr count",  we_log.size(), 2);
        if (we_log.size() == 2) begin
            check("wr0", we_log[0], {5'd3, 8'hAA});
            check("wr1", we_log[1], {5'd4, 8'hBB});
        end
        check("wr nack_err", nack_err, 0);

        run_vectors(6, 14);
        check("rd count", re_log.size(), 3);
        if (re_log.size() == 3) begin
            check("rd addr0", re_log[0], 31);
            check("rd addr1", re_log[1], 0);
            check("rd addr2", re_log[2], 1);
        end
        check("rd nack_err", nack_err, 1);
        check("rd no writes", we_log.size(), 2);

        snap_low = sda_low_cnt;
        snap_we  = we_log.size();
        snap_re  = re_log.size();
        run_vectors(15, 18);
        check("foreign sda driven", sda_low_cnt - snap_low, 0);
        check("foreign mem_we", we_log.size() - snap_we, 0);
        check("foreign mem_re", re_log.size() - snap_re, 0);

        // two-clk SDA glitch while SCL high
        m_sda = 1'b0;
        clks(2);
        m_sda = 1'b1;
        clks(20);
        check("glitch busy", busy, 0);

        // STOP in the middle of a data byte
        do_start();
        write_byte(8'h84, b);
        check("partial addr ack", b, 0);
        write_byte(8'h05, b);
        check("partial ptr ack", b, 0);
        snap_we = we_log.size();
        send_bit(1'b1, b);
        send_bit(1'b0, b);
        send_bit(1'b1, b);
        send_bit(1'b1, b);
        do_stop();
        check("partial mem_we", we_log.size() - snap_we, 0);
        check("partial busy", busy, 0);
        check("partial sda_t", sda_t, 1);
        check("partial ptr", mem_addr, 5);
        check("partial nack_err sticky", nack_err, 1);

        // reset while the slave holds ACK
        do_start();
        for (int i = 7; i >= 0; i--) begin
            ack_b = 8'h84;
            send_bit(ack_b[i], b);
        end
        m_sda = 1'b1;
        clks(Q);
        check("ack driven", sda_t, 0);
        rst = 1'b1;
        #1;
        check("async release", sda_t, 1);
        check("async busy", busy, 0);
        m_scl = 1'b1;
        clks(5);
        rst = 1'b0;
        clks(20);
        check("post rst ptr", mem_addr, 0);
        check("post rst nack_err", nack_err, 0);
        snap_we = we_log.size();
        run_vectors(19, 23);
        check("post rst wr count", we_log.size() - snap_we, 1);
        if (we_log.size() > 0) check("post rst wr", we_log[we_log.size()-1], {5'd7, 8'h3C});

        check("we/re overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_burst.md
I2C_SLAVE_BURST -- requirements
Module: i2c_slave_burst

Interface
REQ-001 SHALL provide parameter DEV_ADDR, default 7'h42, the 7-bit device address this slave answers to.
REQ-002 SHALL provide parameter REG_AW, default 5, the register pointer width (1..8); the register space is 2**REG_AW bytes.
REQ-003 SHALL provide parameter FILT_LEN, default 3, the number of consecutive equal clk samples needed to accept a new SCL/SDA level.
REQ-004 SHALL have port: clk  input  1  system clock; one clock, all state on posedge clk.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: scl_i, sda_i  input  1  raw bus levels, asynchronous to clk.
REQ-007 SHALL have ports: scl_o, scl_t, sda_o, sda_t  output  1  open-drain pad controls; t=1 means released, o is held 0.
REQ-008 SHALL have port: mem_addr  output  REG_AW  register pointer.
REQ-009 SHALL have ports: mem_we  output  1  one-clk write strobe; mem_wdata  output  8  write byte.
REQ-010 SHALL have ports: mem_re  output  1  one-clk read strobe; mem_rdata  input  8  valid on the clk after mem_re.
REQ-011 SHALL have ports: busy  output  1  addressed transaction in progress; nack_err  output  1  sticky, set when the master NACKs mid-burst.

Function
REQ-012 SHALL pass scl_i/sda_i through a 2-flop synchroniser and then a FILT_LEN glitch filter, and use only the filtered levels.
REQ-013 SHALL detect START as a filtered SDA fall with SCL high, and STOP as a filtered SDA rise with SCL high; each produces a one-clk pulse.
REQ-014 SHALL sample SDA on the filtered SCL rising-edge clk and update sda_t on the clk after the filtered SCL falling edge.
REQ-015 SHALL implement the FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-016 SHALL go from any state to ADDR on START (repeated START included), and from any state to IDLE on STOP.
REQ-017 SHALL, in ADDR, shift 8 bits MSB-first; if bits[7:1]==DEV_ADDR the next state is ADDR_ACK (drive SDA low for the 9th bit), otherwise IGNORE (release SDA until START/STOP).
REQ-018 SHALL, after ADDR_ACK with R/W=0, go to PTR; the received byte's low REG_AW bits load the pointer, PTR_ACK ACKs, then the FSM goes to WDATA.
REQ-019 SHALL, in WDATA, receive a byte, pulse mem_we for one clk with mem_wdata=byte and mem_addr=pointer, ACK in WDATA_ACK, and increment the pointer modulo 2**REG_AW (wrapping max to 0).
REQ-020 SHALL, after ADDR_ACK with R/W=1, pulse mem_re at the ADDR_ACK SCL falling edge, latch mem_rdata one clk later, and shift it out MSB-first in RDATA.
REQ-021 SHALL, in RDATA_ACK, release SDA and sample the master's bit: on ACK(0) increment the pointer, pulse mem_re and return to RDATA; on NACK(1) go to IGNORE.
REQ-022 SHALL set nack_err on a NACK in RDATA_ACK only after at least 1 byte has been ACKed in the same burst, and clear it only on reset.
REQ-023 SHALL keep busy=1 in every state except IDLE and IGNORE.
REQ-024 SHALL keep the pointer across a repeated START, so write-pointer-then-Sr-read reads from the set pointer.
REQ-025 SHALL never assert mem_we and mem_re in the same clk.
REQ-026 SHALL discard a partially received byte at START or STOP (no mem_we).
REQ-027 SHALL hold scl_t=1 always; no clock stretching.

Reset
REQ-028 SHALL, while rst=1, force the state to IDLE, pointer=0, bit count=0, sda_t=1, scl_t=1, mem_we=0, mem_re=0, mem_wdata=0, busy=0, nack_err=0, and filters and synchronisers to 1 (bus idle).
REQ-029 SHALL, when reset is applied mid-transfer, release SDA immediately (asynchronously) and resume at IDLE waiting for the next START.

Structure
REQ-030 SHALL place the FSM state encoding and the ACK/NACK bit constants in a shared package, i2c_pkg.
REQ-031 SHALL implement the synchroniser and filter as sub-module i2c_in_filter, instantiated once each for SCL and SDA.

Verification
REQ-032 SHALL test a write burst: START,0x84,0x03,0xAA,0xBB,STOP -> 3 ACKs to pointer and data, mem_we at addr 3 with 0xAA, then at addr 4 with 0xBB.
REQ-033 SHALL test a combined read: START,0x84,0x1F,Sr,0x85, master ACK,ACK,NACK, STOP -> reads from addr 31, 0, 1 (wrap); nack_err=1.
REQ-034 SHALL test a wrong address: START,0x90,... -> SDA never driven, no mem_we/mem_re, busy=0.
REQ-035 SHALL test a glitch: a 2-clk SDA low pulse with SCL high and FILT_LEN=3 -> no START detected.
REQ-036 SHALL test a STOP after 4 data bits in WDATA -> no mem_we, state IDLE, sda_t=1.
REQ-037 SHALL test rst=1 asserted while driving ACK -> sda_t=1 within the same clk, and the next transfer succeeds.
